// File: rtl/pong_matrix_display.sv
// Pong display back end: per-frame game-state snapshot, 8x8 LED matrix row scan
// with leading blank per row, and a two-digit 7-segment score multiplexer.
module pong_matrix_display #(
  parameter int ROW_CYCLES   = 1000,
  parameter int BLANK_CYCLES = 50,
  parameter int PAD_W        = 3,
  parameter int BLINK_BIT    = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [2:0] i_ball_x,
  input  logic [2:0] i_ball_y,
  input  logic [2:0] i_pad_a,
  input  logic [2:0] i_pad_b,
  input  logic       i_playing,
  input  logic [3:0] i_score_a,
  input  logic [3:0] i_score_b,
  output logic [7:0] o_row_sel,
  output logic [7:0] o_col,
  output logic [6:0] o_seg,
  output logic [1:0] o_dig_sel,
  output logic       o_frame_start
);

  localparam int CW = (ROW_CYCLES > 2) ? $clog2(ROW_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST  = CW'(ROW_CYCLES - 1);
  localparam logic [CW-1:0] CYC_BLANK = CW'(BLANK_CYCLES);
  localparam logic [3:0]    PAD_SPAN  = 4'(PAD_W - 1);

  logic [CW-1:0]      r_cyc_cnt;
  logic [2:0]         r_row_cnt;
  logic [BLINK_BIT:0] r_frame_cnt;

  logic [2:0] r_snap_ball_x;
  logic [2:0] r_snap_ball_y;
  logic [2:0] r_snap_pad_a;
  logic [2:0] r_snap_pad_b;
  logic       r_snap_playing;
  logic [3:0] r_snap_score_a;
  logic [3:0] r_snap_score_b;

  logic       w_snap_now;
  logic       w_row_last;
  logic       w_blank;
  logic       w_ball_on;
  logic [7:0] w_pattern;
  logic [3:0] w_digit;

  // Paddle mask; the right edge is computed at 4 bits so it can exceed 7 and
  // clip naturally instead of wrapping back to column 0.
  function automatic logic [7:0] pad_mask(input logic [2:0] left);
    logic [3:0] lo;
    logic [3:0] hi;
    logic [7:0] m;
    lo = {1'b0, left};
    hi = lo + PAD_SPAN;
    m  = '0;
    for (int c = 0; c < 8; c++) begin
      if ((4'(c) >= lo) && (4'(c) <= hi)) begin
        m[c] = 1'b1;
      end
    end
    return m;
  endfunction

  function automatic logic [6:0] hex7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign w_snap_now = (r_row_cnt == 3'd0) && (r_cyc_cnt == '0);
  assign w_row_last = (r_cyc_cnt == CYC_LAST);
  assign w_blank    = (r_cyc_cnt < CYC_BLANK);
  assign w_ball_on  = r_snap_playing | r_frame_cnt[BLINK_BIT];
  assign w_digit    = r_row_cnt[0] ? r_snap_score_b : r_snap_score_a;

  always_comb begin
    w_pattern = '0;
    if (r_row_cnt == 3'd0) begin
      w_pattern = w_pattern | pad_mask(r_snap_pad_a);
    end
    if (r_row_cnt == 3'd7) begin
      w_pattern = w_pattern | pad_mask(r_snap_pad_b);
    end
    if (w_ball_on && (r_row_cnt == r_snap_ball_y)) begin
      w_pattern[r_snap_ball_x] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cyc_cnt      <= '0;
      r_row_cnt      <= '0;
      r_frame_cnt    <= '0;
      r_snap_ball_x  <= '0;
      r_snap_ball_y  <= '0;
      r_snap_pad_a   <= '0;
      r_snap_pad_b   <= '0;
      r_snap_playing <= 1'b0;
      r_snap_score_a <= '0;
      r_snap_score_b <= '0;
      o_row_sel      <= '0;
      o_col          <= '0;
      o_seg          <= '0;
      o_dig_sel      <= '0;
      o_frame_start  <= 1'b0;
    end else begin
      if (w_row_last) begin
        r_cyc_cnt <= '0;
        r_row_cnt <= r_row_cnt + 3'd1;
      end else begin
        r_cyc_cnt <= r_cyc_cnt + CW'(1);
      end

      o_frame_start <= w_snap_now;
      if (w_snap_now) begin
        r_snap_ball_x  <= i_ball_x;
        r_snap_ball_y  <= i_ball_y;
        r_snap_pad_a   <= i_pad_a;
        r_snap_pad_b   <= i_pad_b;
        r_snap_playing <= i_playing;
        r_snap_score_a <= i_score_a;
        r_snap_score_b <= i_score_b;
        r_frame_cnt    <= r_frame_cnt + 1'b1;
      end

      // Outputs follow the pre-edge scan position; the blank slot at cycle 0
      // hides the row-0 pattern on the very edge that refreshes the snapshot.
      o_row_sel <= 8'b1 << r_row_cnt;
      o_dig_sel <= r_row_cnt[0] ? 2'b10 : 2'b01;
      if (w_blank) begin
        o_col <= '0;
        o_seg <= '0;
      end else begin
        o_col <= w_pattern;
        o_seg <= hex7(w_digit);
      end
    end
  end

endmodule

// File: tb/tb_pong_matrix_display.sv
// Directed bench for pong_matrix_display with a 4-clock row slot and 1-clock blank.
module tb_pong_matrix_display;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] ball_x, ball_y, pad_a, pad_b;
  logic       playing;
  logic [3:0] score_a, score_b;
  logic [7:0] row_sel, col;
  logic [6:0] seg;
  logic [1:0] dig_sel;
  logic       frame_start;

  int errors = 0;
  int checks = 0;
  int frames = 0;
  int pos    = 0;

  pong_matrix_display #(
    .ROW_CYCLES(4), .BLANK_CYCLES(1), .PAD_W(3), .BLINK_BIT(1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_ball_x(ball_x), .i_ball_y(ball_y),
    .i_pad_a(pad_a), .i_pad_b(pad_b),
    .i_playing(playing),
    .i_score_a(score_a), .i_score_b(score_b),
    .o_row_sel(row_sel), .o_col(col), .o_seg(seg),
    .o_dig_sel(dig_sel), .o_frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Waits for the next frame_start pulse; pos 0 is then the row-0 blank slot.
  task automatic wait_frame(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 100);
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL frame_start_timeout: frame_start=%b after %0d clocks, required 1", frame_start, n);
    end
    frames++;
    pos = 0;
  endtask

  task automatic at(input int r, input int k);
    int target;
    target = 4 * r + k;
    while (pos < target) begin
      @(negedge clk);
      pos++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    ball_x = 3; ball_y = 5; pad_a = 0; pad_b = 0;
    playing = 1'b1; score_a = 0; score_b = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({row_sel, col, seg, dig_sel, frame_start} !== 26'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0", {row_sel, col, seg, dig_sel, frame_start});
    end
    rst_n = 1'b1;
    @(negedge clk);
    frames = 1; pos = 0;
    checks++;
    if (row_sel !== 8'h01 || col !== 8'h00 || frame_start !== 1'b1 || dig_sel !== 2'b01) begin
      errors++;
      $display("FAIL edge1: row_sel=%h col=%h fs=%b dig=%b, required 01 00 1 01", row_sel, col, frame_start, dig_sel);
    end
    @(negedge clk);
    pos = 1;
    checks++;
    if (frame_start !== 1'b0 || col !== 8'h07) begin
      errors++;
      $display("FAIL edge2: fs=%b col=%h, required 0 07", frame_start, col);
    end
    at(1, 0);
    checks++;
    if (row_sel !== 8'h02) begin
      errors++;
      $display("FAIL edge5_row_sel: got %h, required 02", row_sel);
    end
  endtask

  task automatic test_paddle_clip;
    int n;
    pad_a = 6; pad_b = 5;
    wait_frame(n);
    at(0, 1);
    checks++;
    if (col !== 8'hC0) begin
      errors++;
      $display("FAIL pad_a_clip: col=%h, required C0", col);
    end
    at(7, 2);
    checks++;
    if (col !== 8'hE0 || row_sel !== 8'h80) begin
      errors++;
      $display("FAIL pad_b_clip: col=%h row_sel=%h, required E0 80", col, row_sel);
    end
    pad_a = 0; pad_b = 0;
    wait_frame(n);
    at(0, 3);
    checks++;
    if (col !== 8'h07) begin
      errors++;
      $display("FAIL pad_a_zero: col=%h, required 07", col);
    end
  endtask

  task automatic test_ball;
    int n;
    wait_frame(n);
    at(5, 1);
    checks++;
    if (col !== 8'h08 || row_sel !== 8'h20) begin
      errors++;
      $display("FAIL ball_row5: col=%h row_sel=%h, required 08 20", col, row_sel);
    end
    at(7, 1);
    checks++;
    if (col !== 8'h07) begin
      errors++;
      $display("FAIL pad_b_row7: col=%h, required 07", col);
    end
    ball_x = 1; ball_y = 7;
    wait_frame(n);
    at(5, 2);
    checks++;
    if (col !== 8'h00) begin
      errors++;
      $display("FAIL ball_moved_row5: col=%h, required 00", col);
    end
    at(7, 2);
    checks++;
    if (col !== 8'h07) begin
      errors++;
      $display("FAIL ball_merged: col=%h, required 07", col);
    end
    ball_x = 5;
    wait_frame(n);
    at(7, 3);
    checks++;
    if (col !== 8'h27) begin
      errors++;
      $display("FAIL ball_beside_pad: col=%h, required 27", col);
    end
    ball_x = 3; ball_y = 5;
  endtask

  task automatic test_snapshot_latency;
    int n;
    wait_frame(n);
    at(2, 1);
    ball_x = 6;
    at(5, 1);
    checks++;
    if (col !== 8'h08) begin
      errors++;
      $display("FAIL latency_same_frame: col=%h, required 08", col);
    end
    at(7, 3);
    checks++;
    if (col !== 8'h07) begin
      errors++;
      $display("FAIL latency_row7: col=%h, required 07", col);
    end
    wait_frame(n);
    at(5, 1);
    checks++;
    if (col !== 8'h40) begin
      errors++;
      $display("FAIL latency_next_frame: col=%h, required 40", col);
    end
    ball_x = 3;
  endtask

  task automatic test_blink;
    int n;
    logic [1:0] fc;
    logic [7:0] exp_col;
    wait_frame(n);
    playing = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_frame(n);
      fc = 2'(frames);
      exp_col = fc[1] ? 8'h08 : 8'h00;
      at(0, 1);
      checks++;
      if (col !== 8'h07) begin
        errors++;
        $display("FAIL blink_paddle frame %0d: col=%h, required 07", fc, col);
      end
      at(5, 2);
      checks++;
      if (col !== exp_col) begin
        errors++;
        $display("FAIL blink_ball frame %0d: col=%h, required %h", fc, col, exp_col);
      end
    end
    playing = 1'b1;
  endtask

  task automatic test_scores;
    int n;
    score_a = 7; score_b = 10;
    wait_frame(n);
    checks++;
    if (seg !== 7'h00 || dig_sel !== 2'b01) begin
      errors++;
      $display("FAIL score_blank_even: seg=%h dig=%b, required 00 01", seg, dig_sel);
    end
    at(0, 1);
    checks++;
    if (seg !== 7'h07 || dig_sel !== 2'b01) begin
      errors++;
      $display("FAIL score_a_7: seg=%h dig=%b, required 07 01", seg, dig_sel);
    end
    at(1, 0);
    checks++;
    if (seg !== 7'h00 || dig_sel !== 2'b10) begin
      errors++;
      $display("FAIL score_blank_odd: seg=%h dig=%b, required 00 10", seg, dig_sel);
    end
    at(1, 2);
    checks++;
    if (seg !== 7'h77 || dig_sel !== 2'b10) begin
      errors++;
      $display("FAIL score_b_A: seg=%h dig=%b, required 77 10", seg, dig_sel);
    end
    at(6, 3);
    checks++;
    if (seg !== 7'h07 || dig_sel !== 2'b01) begin
      errors++;
      $display("FAIL score_row6: seg=%h dig=%b, required 07 01", seg, dig_sel);
    end
    score_a = 15; score_b = 0;
    wait_frame(n);
    at(0, 1);
    checks++;
    if (seg !== 7'h71) begin
      errors++;
      $display("FAIL score_a_F: seg=%h, required 71", seg);
    end
    at(3, 1);
    checks++;
    if (seg !== 7'h3F) begin
      errors++;
      $display("FAIL score_b_0: seg=%h, required 3F", seg);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    wait_frame(n);
    at(4, 2);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({row_sel, col, seg, dig_sel, frame_start} !== 26'd0) begin
      errors++;
      $display("FAIL async_reset: got %h, required 0", {row_sel, col, seg, dig_sel, frame_start});
    end
    @(negedge clk);
    rst_n = 1'b1;
    frames = 0;
    wait_frame(n);
    checks++;
    if (n !== 1 || row_sel !== 8'h01 || col !== 8'h00) begin
      errors++;
      $display("FAIL restart: clocks=%0d row_sel=%h col=%h, required 1 01 00", n, row_sel, col);
    end
    at(1, 1);
    checks++;
    if (row_sel !== 8'h02 || seg !== 7'h3F) begin
      errors++;
      $display("FAIL restart_row1: row_sel=%h seg=%h, required 02 3F", row_sel, seg);
    end
  endtask

  initial begin
    test_reset();
    test_paddle_clip();
    test_ball();
    test_snapshot_latency();
    test_blink();
    test_scores();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
